tow_referee: RTL and testbench
==============================

Name: tow_referee

Overview:
- Downstream game controller for the Tug-of-War push-button latch.
- Consumes the latch's push/tie/right flags and moves a one-hot "rope" position along an LED bar.
- Drives the latch's clr input to re-arm it for the next round.
- Detects and holds a winner when the position reaches either end of the bar.

Parameters:
- NUM_LEDS, 9: LED bar length. Must be odd and >= 5. Centre index is CENTRE = (NUM_LEDS-1)/2.
- SETTLE_CYCLES, 4: cycles to wait after push rises before sampling tie/right. Must be >= 1.
- CLR_CYCLES, 2: minimum cycles clr is asserted per round. Must be >= 1.
- FLASH_DIV, 8: half-period, in cycles, of the winner LED blink. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- push  in  1  latch flag: at least one player has pressed.
- tie  in  1  latch flag: both players pressed simultaneously.
- right  in  1  latch flag: right player pressed first.
- clr  out  1  registered; clears the latch while 1.
- leds  out  NUM_LEDS  one-hot rope position; bit 0 is the left end.
- pos  out  $clog2(NUM_LEDS)  binary rope position.
- game_over  out  1  registered; 1 once a winner is decided.
- winner_right  out  1  registered; 1 = right won. Meaningful only when game_over = 1.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = CLEAR with the clear counter loaded to CLR_CYCLES-1.
  - clr = 1, pos = CENTRE, leds = one-hot at CENTRE.
  - game_over = 0, winner_right = 0.
- State ARMED:
  - clr = 0.
  - When push = 1 at a rising edge, go to SETTLE and load the settle counter with SETTLE_CYCLES-1.
- State SETTLE:
  - clr = 0; decrement the settle counter each cycle.
  - When the counter is 0, go to EVAL.
  - Inputs are ignored in this state, so the latch has SETTLE_CYCLES cycles to resolve a tie.
- State EVAL (exactly 1 cycle):
  - Sample tie and right.
  - tie = 1: pos unchanged.
  - else right = 1: pos + 1.
  - else: pos - 1.
  - pos saturates at 0 and NUM_LEDS-1; no wrap-around.
  - Next state is CLEAR; load the clear counter with CLR_CYCLES-1 and set clr = 1 from the next cycle.
- State CLEAR:
  - clr = 1; decrement the clear counter.
  - Leave only when the counter is 0 AND push = 0.
  - If push is still 1 when the counter expires, stay in CLEAR with clr held at 1.
  - Exit to WIN if pos is 0 or NUM_LEDS-1; otherwise exit to ARMED.
- State WIN (terminal until reset):
  - clr = 1, game_over = 1.
  - winner_right = 1 if pos = NUM_LEDS-1, 0 if pos = 0.
  - push, tie and right are ignored.
- Output timing:
  - leds and pos update on the cycle after EVAL.
  - game_over and winner_right assert on the first cycle of WIN.
- Latency: from push rising (sampled) to pos change is SETTLE_CYCLES + 1 edges.
- Simultaneous presses: resolved entirely by the tie input; no move.
- Reset mid-round (any state): immediate return to the reset values. The round is discarded and pos returns to CENTRE.
- Glitch on push in ARMED:
  - Any single-cycle sampled push commits a round.
  - If, in EVAL, push has fallen and tie = right = 0, this counts as a left press; that is intended, because the latch only drops push on clr.

Optional Feature:
- Macro: TOW_WIN_FLASH_EN.
- Defined:
  - In WIN, the winning end LED toggles every FLASH_DIV cycles, starting lit on WIN entry.
  - All other LEDs stay 0.
  - pos is unaffected.
- Undefined:
  - The winning LED is held steady at 1 in WIN.
  - The flash counter is not instantiated.

Decomposition:
- Shared package tow_pkg:
  - state enum {CLEAR, ARMED, SETTLE, EVAL, WIN};
  - function for the centre index;
  - default values of NUM_LEDS, SETTLE_CYCLES and CLR_CYCLES.
- Sub-module tow_led_decode: purely combinational, converts pos to one-hot leds.
- The flash gating stays in the top-level module.

Test Plan (NUM_LEDS=9, SETTLE_CYCLES=4, CLR_CYCLES=2, FLASH_DIV=8):
- Reset check: assert rst = 0 for 3 cycles, then release.
  - Required: during reset, clr = 1, pos = 4, leds = 9'b000010000.
  - Required: clr falls 2 cycles after release (push = 0).
- Single right press: push = 1, right = 1 for 1 cycle.
  - Required: pos = 5 exactly 5 edges after push is sampled.
  - Required: then clr = 1 for 2 cycles, then the block is back in ARMED.
- Tie round: push = tie = right = 1.
  - Required: pos stays 4; clr is still pulsed for 2 cycles.
- Stuck push: hold push = 1 through CLEAR for 10 cycles.
  - Required: clr stays 1 for all 10 cycles.
  - Required: after push drops, clr falls on the next edge.
  - Required: no second move occurs.
- Left win: 4 consecutive left rounds from reset.
  - Required: pos = 0, game_over = 1, winner_right = 0, clr = 1.
  - Required: a further push has no effect.
- Reset mid-SETTLE, then flash:
  - Drop rst during SETTLE. Required: pos = 4 and clr = 1 immediately.
  - With TOW_WIN_FLASH_EN, after a right win: leds toggles between 9'b100000000 and 0 every 8 cycles.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared types and defaults for the Tug-of-War referee.
package tow_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    ARMED,
    SETTLE,
    EVAL,
    WIN
  } tow_state_e;

  localparam int DEF_NUM_LEDS      = 9;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_CLR_CYCLES    = 2;
  localparam int DEF_FLASH_DIV     = 8;

  function automatic int centre_idx(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/tow_led_decode.sv
// Combinational binary-to-one-hot decode of the rope position onto the LED bar.
module tow_led_decode #(
  parameter int NUM_LEDS = 9,
  parameter int PW       = 4
) (
  input  logic [PW-1:0]       pos_i,
  output logic [NUM_LEDS-1:0] leds_o
);

  always_comb begin
    leds_o = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      leds_o[i] = (pos_i == PW'(i));
    end
  end

endmodule

// File: rtl/tow_referee.sv
// Tug-of-War referee: consumes latch push/tie/right flags, moves the rope, re-arms the latch, holds the winner.
// Optional macro TOW_WIN_FLASH_EN blinks the winning LED every FLASH_DIV cycles instead of holding it lit.
module tow_referee
  import tow_pkg::*;
#(
  parameter int NUM_LEDS      = DEF_NUM_LEDS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CLR_CYCLES    = DEF_CLR_CYCLES,
  parameter int FLASH_DIV     = DEF_FLASH_DIV
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        tie,
  input  logic                        right,
  output logic                        clr,
  output logic [NUM_LEDS-1:0]         leds,
  output logic [$clog2(NUM_LEDS)-1:0] pos,
  output logic                        game_over,
  output logic                        winner_right
);

  localparam int PW   = $clog2(NUM_LEDS);
  localparam int CMAX = (SETTLE_CYCLES > CLR_CYCLES) ? SETTLE_CYCLES : CLR_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [PW-1:0] POS_MAX = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0] POS_CTR = PW'(centre_idx(NUM_LEDS));

  generate
    if (NUM_LEDS < 5 || (NUM_LEDS % 2) == 0) begin : g_bad_num_leds
      $error("tow_referee: NUM_LEDS must be odd and >= 5");
    end
    if (SETTLE_CYCLES < 1 || CLR_CYCLES < 1 || FLASH_DIV < 1) begin : g_bad_cycles
      $error("tow_referee: SETTLE_CYCLES, CLR_CYCLES and FLASH_DIV must be >= 1");
    end
  endgenerate

  tow_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          clr_q, clr_d;
  logic          game_over_q, game_over_d;
  logic          winner_right_q, winner_right_d;
  logic [NUM_LEDS-1:0] leds_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= CLEAR;
      cnt_q          <= CW'(CLR_CYCLES - 1);
      pos_q          <= POS_CTR;
      clr_q          <= 1'b1;
      game_over_q    <= 1'b0;
      winner_right_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pos_q          <= pos_d;
      clr_q          <= clr_d;
      game_over_q    <= game_over_d;
      winner_right_q <= winner_right_d;
    end
  end

  // One counter serves both SETTLE and CLEAR; the two never overlap.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pos_d          = pos_q;
    game_over_d    = game_over_q;
    winner_right_d = winner_right_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!push) begin
          if (pos_q == '0 || pos_q == POS_MAX) begin
            state_d        = WIN;
            game_over_d    = 1'b1;
            winner_right_d = (pos_q == POS_MAX);
          end else begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (push) begin
          state_d = SETTLE;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      EVAL: begin
        if (!tie) begin
          if (right) begin
            if (pos_q != POS_MAX) pos_d = pos_q + PW'(1);
          end else begin
            if (pos_q != '0) pos_d = pos_q - PW'(1);
          end
        end
        state_d = CLEAR;
        cnt_d   = CW'(CLR_CYCLES - 1);
      end
      WIN: begin
        state_d = WIN;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = CW'(CLR_CYCLES - 1);
      end
    endcase
    clr_d = (state_d == CLEAR) || (state_d == WIN);
  end

  tow_led_decode #(
    .NUM_LEDS(NUM_LEDS),
    .PW      (PW)
  ) u_led_decode (
    .pos_i (pos_q),
    .leds_o(leds_raw)
  );

`ifdef TOW_WIN_FLASH_EN
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  logic [FW-1:0] flash_cnt_q;
  logic          flash_on_q;

  // Phase restarts on WIN entry so the winning LED is lit for the first full half-period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
    end else if (state_q != WIN) begin
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
    end else if (flash_cnt_q == FW'(FLASH_DIV - 1)) begin
      flash_cnt_q <= '0;
      flash_on_q  <= ~flash_on_q;
    end else begin
      flash_cnt_q <= flash_cnt_q + FW'(1);
    end
  end

  assign leds = leds_raw & {NUM_LEDS{flash_on_q}};
`else
  assign leds = leds_raw;
`endif

  assign clr          = clr_q;
  assign pos          = pos_q;
  assign game_over    = game_over_q;
  assign winner_right = winner_right_q;

endmodule

// File: tb/tb_tow_referee.sv
// Directed self-checking bench for tow_referee with NUM_LEDS=9, SETTLE_CYCLES=4, CLR_CYCLES=2, FLASH_DIV=8.
module tb_tow_referee;

  logic       clk;
  logic       rst_n;
  logic       push, tie, right;
  logic       clr;
  logic [8:0] leds;
  logic [3:0] pos;
  logic       game_over, winner_right;

  int n_checks = 0;
  int n_pass   = 0;

  tow_referee #(
    .NUM_LEDS     (9),
    .SETTLE_CYCLES(4),
    .CLR_CYCLES   (2),
    .FLASH_DIV    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .push        (push),
    .tie         (tie),
    .right       (right),
    .clr         (clr),
    .leds        (leds),
    .pos         (pos),
    .game_over   (game_over),
    .winner_right(winner_right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] onehot(input int p);
    logic [31:0] v;
    v = 32'd1;
    return v << p;
  endfunction

  // Latch-like round: flags held until clr rises, then dropped.
  task automatic do_round(input logic t, input logic r, input int p0, input int p1, input logic win);
    push = 1'b1;
    tie  = t;
    right = r;
    repeat (5) tick();
    check("pos_before_eval", pos, p0);
    tick();
    check("pos_after_eval", pos, p1);
    check("leds_after_eval", leds, onehot(p1));
    check("clr_rise", clr, 1);
    push = 1'b0;
    tie  = 1'b0;
    right = 1'b0;
    tick();
    check("clr_second_cycle", clr, 1);
    tick();
    check("clr_end_of_round", clr, win);
    check("game_over_end_of_round", game_over, win);
  endtask

  initial begin
    logic [31:0] exp_leds;
    rst_n = 1'b0;
    push  = 1'b0;
    tie   = 1'b0;
    right = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_clr", clr, 1);
    check("rst_pos", pos, 4);
    check("rst_leds", leds, 32'h010);
    check("rst_game_over", game_over, 0);
    check("rst_winner_right", winner_right, 0);
    rst_n = 1'b1;
    tick();
    check("clr_after_release_1", clr, 1);
    tick();
    check("clr_after_release_2", clr, 0);

    do_round(1'b1, 1'b1, 4, 4, 1'b0);
    do_round(1'b0, 1'b1, 4, 5, 1'b0);

    push = 1'b1;
    repeat (6) tick();
    check("stuck_pos_move", pos, 4);
    check("stuck_clr_rise", clr, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stuck_clr_held", clr, 1);
    end
    push = 1'b0;
    tick();
    check("stuck_clr_fall", clr, 0);
    check("stuck_no_second_move", pos, 4);

    do_round(1'b0, 1'b1, 4, 5, 1'b0);
    push  = 1'b1;
    right = 1'b1;
    tick();
    tick();
    check("settle_clr_low", clr, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_pos", pos, 4);
    check("midreset_clr", clr, 1);
    check("midreset_leds", leds, 32'h010);
    push  = 1'b0;
    right = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    check("midreset_rearm", clr, 0);

    do_round(1'b0, 1'b0, 4, 3, 1'b0);
    do_round(1'b0, 1'b0, 3, 2, 1'b0);
    do_round(1'b0, 1'b0, 2, 1, 1'b0);
    do_round(1'b0, 1'b0, 1, 0, 1'b1);
    check("left_win_winner_right", winner_right, 0);
    check("left_win_leds", leds, 32'h001);
    push  = 1'b1;
    right = 1'b1;
    repeat (10) tick();
    check("win_ignores_push_pos", pos, 0);
    check("win_ignores_push_go", game_over, 1);
    check("win_ignores_push_clr", clr, 1);
    push  = 1'b0;
    right = 1'b0;

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    do_round(1'b0, 1'b1, 4, 5, 1'b0);
    do_round(1'b0, 1'b1, 5, 6, 1'b0);
    do_round(1'b0, 1'b1, 6, 7, 1'b0);
    do_round(1'b0, 1'b1, 7, 8, 1'b1);
    check("right_win_winner_right", winner_right, 1);
    check("right_win_leds_entry", leds, 32'h100);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 7 || k == 8 || k == 15 || k == 16) begin
`ifdef TOW_WIN_FLASH_EN
        exp_leds = (((k / 8) % 2) == 1) ? 32'h000 : 32'h100;
`else
        exp_leds = 32'h100;
`endif
        check("right_win_leds_phase", leds, exp_leds);
      end
    end
    check("right_win_pos_steady", pos, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
